// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/control bundle between the issuing stage and the muldiv sequencer.
interface muldiv_sequencer_if;
    logic       op_valid;
    logic [5:0] funct;
    logic       stall;
    logic [5:0] ctrl_code;
    logic       busy;
    logic       hilo_wr;
    logic       op_done;
    logic       illegal;
    modport master (
        output op_valid, funct,
        input  stall, ctrl_code, busy, hilo_wr, op_done, illegal
    );
    modport slave (
        input  op_valid, funct,
        output stall, ctrl_code, busy, hilo_wr, op_done, illegal
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: issues ALU/shift ops in one cycle and sequences MULTU/DIVU iterations ending in a HiLo write.
module muldiv_sequencer #(
    parameter int ITER_CYCLES = 32,
    parameter int CNT_W       = 6
) (
    input logic                clk,
    input logic                rst,
    muldiv_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       op_q, op_d, ctrl_code_q, ctrl_code_d;
    logic             busy_q, busy_d, hilo_wr_q, hilo_wr_d;
    logic             op_done_q, op_done_d, illegal_q, illegal_d;
    logic             is_single, is_multi;
    assign is_single = bus.funct inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd16, 6'd18};
    assign is_multi  = bus.funct inside {6'd25, 6'd27};
    assign bus.stall     = bus.op_valid & (state_q != IDLE);
    assign bus.ctrl_code = ctrl_code_q;
    assign bus.busy      = busy_q;
    assign bus.hilo_wr   = hilo_wr_q;
    assign bus.op_done   = op_done_q;
    assign bus.illegal   = illegal_q;
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        ctrl_code_d = 6'd0;
        busy_d      = 1'b0;
        hilo_wr_d   = 1'b0;
        op_done_d   = 1'b0;
        illegal_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.op_valid) begin
                if (is_single) begin
                    ctrl_code_d = bus.funct;
                    op_done_d   = 1'b1;
                end else if (is_multi) begin
                    op_d        = bus.funct;
                    cnt_d       = '0;
                    ctrl_code_d = bus.funct;
                    busy_d      = 1'b1;
                    state_d     = RUN;
                end else begin
                    illegal_d   = 1'b1;
                end
            end
            RUN: begin
                // the latched op, not the live funct, drives the datapath for the whole iteration
                cnt_d       = cnt_q + CNT_W'(1);
                busy_d      = 1'b1;
                ctrl_code_d = op_q;
                if (cnt_q == CNT_W'(ITER_CYCLES - 1)) begin
                    state_d     = WRITE;
                    ctrl_code_d = 6'b111111;
                    hilo_wr_d   = 1'b1;
                    op_done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= 6'd0;
            ctrl_code_q <= 6'd0;
            busy_q      <= 1'b0;
            hilo_wr_q   <= 1'b0;
            op_done_q   <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            ctrl_code_q <= ctrl_code_d;
            busy_q      <= busy_d;
            hilo_wr_q   <= hilo_wr_d;
            op_done_q   <= op_done_d;
            illegal_q   <= illegal_d;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed scenarios for the muldiv sequencer with hand-computed expectations.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    muldiv_sequencer_if bus();
    muldiv_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask
    task automatic test_reset();
        bus.op_valid = 1'b0;
        bus.funct = 6'd0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (bus.ctrl_code !== 6'd0) begin failures++; $display("FAIL rst_ctrl got=%0d exp=0", bus.ctrl_code); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.hilo_wr !== 1'b0) begin failures++; $display("FAIL rst_hilo got=%0b exp=0", bus.hilo_wr); end
        checks++; if (bus.op_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", bus.op_done); end
        checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL rst_illegal got=%0b exp=0", bus.illegal); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", bus.stall); end
    endtask
    task automatic test_single();
        bus.op_valid = 1'b1;
        bus.funct = 6'd32;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL add_stall got=%0b exp=0", bus.stall); end
        step();
        bus.op_valid = 1'b0;
        checks++; if (bus.ctrl_code !== 6'd32) begin failures++; $display("FAIL add_ctrl got=%0d exp=32", bus.ctrl_code); end
        checks++; if (bus.op_done !== 1'b1) begin failures++; $display("FAIL add_done got=%0b exp=1", bus.op_done); end
        step();
        checks++; if (bus.ctrl_code !== 6'd0) begin failures++; $display("FAIL add_ctrl_after got=%0d exp=0", bus.ctrl_code); end
        checks++; if (bus.op_done !== 1'b0) begin failures++; $display("FAIL add_done_after got=%0b exp=0", bus.op_done); end
    endtask
    task automatic test_back_to_back();
        logic [5:0] ops [6] = '{6'd36, 6'd37, 6'd42, 6'd2, 6'd34, 6'd18};
        for (int i = 0; i < 6; i++) begin
            bus.op_valid = 1'b1;
            bus.funct = ops[i];
            #1;
            checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL b2b_stall[%0d] got=%0b exp=0", i, bus.stall); end
            step();
            checks++; if (bus.ctrl_code !== ops[i]) begin failures++; $display("FAIL b2b_ctrl[%0d] got=%0d exp=%0d", i, bus.ctrl_code, ops[i]); end
            checks++; if (bus.op_done !== 1'b1) begin failures++; $display("FAIL b2b_done[%0d] got=%0b exp=1", i, bus.op_done); end
        end
        bus.op_valid = 1'b0;
        step();
        checks++; if (bus.ctrl_code !== 6'd0) begin failures++; $display("FAIL b2b_idle_ctrl got=%0d exp=0", bus.ctrl_code); end
    endtask
    task automatic test_multu_interlock();
        int hilo_seen = 0;
        bus.op_valid = 1'b1;
        bus.funct = 6'd25;
        step();
        bus.op_valid = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (c >= 5) begin
                bus.op_valid = 1'b1;
                bus.funct = (c == 10) ? 6'd27 : 6'd16;
                #1;
                checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL mul_stall[%0d] got=%0b exp=1", c, bus.stall); end
            end
            checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mul_busy[%0d] got=%0b exp=1", c, bus.busy); end
            checks++; if (bus.ctrl_code !== 6'd25) begin failures++; $display("FAIL mul_ctrl[%0d] got=%0d exp=25", c, bus.ctrl_code); end
            if (bus.hilo_wr === 1'b1) hilo_seen++;
            step();
        end
        checks++; if (bus.ctrl_code !== 6'd63) begin failures++; $display("FAIL mul_wr_ctrl got=%0d exp=63", bus.ctrl_code); end
        checks++; if (bus.hilo_wr !== 1'b1) begin failures++; $display("FAIL mul_wr_hilo got=%0b exp=1", bus.hilo_wr); end
        checks++; if (bus.op_done !== 1'b1) begin failures++; $display("FAIL mul_wr_done got=%0b exp=1", bus.op_done); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mul_wr_busy got=%0b exp=1", bus.busy); end
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL mul_wr_stall got=%0b exp=1", bus.stall); end
        if (bus.hilo_wr === 1'b1) hilo_seen++;
        step();
        if (bus.hilo_wr === 1'b1) hilo_seen++;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mul_end_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.ctrl_code !== 6'd0) begin failures++; $display("FAIL mul_end_ctrl got=%0d exp=0", bus.ctrl_code); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL mul_end_stall got=%0b exp=0", bus.stall); end
        checks++; if (hilo_seen !== 1) begin failures++; $display("FAIL mul_hilo_pulses got=%0d exp=1", hilo_seen); end
        step();
        bus.op_valid = 1'b0;
        checks++; if (bus.ctrl_code !== 6'd16) begin failures++; $display("FAIL mfhi_ctrl got=%0d exp=16", bus.ctrl_code); end
        checks++; if (bus.op_done !== 1'b1) begin failures++; $display("FAIL mfhi_done got=%0b exp=1", bus.op_done); end
        step();
        checks++; if (bus.ctrl_code !== 6'd0) begin failures++; $display("FAIL mfhi_after got=%0d exp=0", bus.ctrl_code); end
    endtask
    task automatic test_reset_mid_divu();
        int hilo_seen = 0;
        bus.op_valid = 1'b1;
        bus.funct = 6'd27;
        step();
        bus.op_valid = 1'b0;
        checks++; if (bus.ctrl_code !== 6'd27) begin failures++; $display("FAIL div_ctrl got=%0d exp=27", bus.ctrl_code); end
        for (int c = 1; c < 10; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.ctrl_code !== 6'd0) begin failures++; $display("FAIL divrst_ctrl got=%0d exp=0", bus.ctrl_code); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL divrst_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.op_done !== 1'b0) begin failures++; $display("FAIL divrst_done got=%0b exp=0", bus.op_done); end
        bus.op_valid = 1'b1;
        bus.funct = 6'd32;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL divrst_stall got=%0b exp=0", bus.stall); end
        step();
        bus.op_valid = 1'b0;
        checks++; if (bus.ctrl_code !== 6'd32) begin failures++; $display("FAIL divrst_add got=%0d exp=32", bus.ctrl_code); end
        for (int c = 0; c < 40; c++) begin
            if (bus.hilo_wr === 1'b1) hilo_seen++;
            step();
        end
        checks++; if (hilo_seen !== 0) begin failures++; $display("FAIL divrst_hilo got=%0d exp=0", hilo_seen); end
    endtask
    task automatic test_illegal();
        bus.op_valid = 1'b1;
        bus.funct = 6'd63;
        step();
        bus.op_valid = 1'b0;
        checks++; if (bus.illegal !== 1'b1) begin failures++; $display("FAIL ill_flag got=%0b exp=1", bus.illegal); end
        checks++; if (bus.ctrl_code !== 6'd0) begin failures++; $display("FAIL ill_ctrl got=%0d exp=0", bus.ctrl_code); end
        checks++; if (bus.op_done !== 1'b0) begin failures++; $display("FAIL ill_done got=%0b exp=0", bus.op_done); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ill_busy got=%0b exp=0", bus.busy); end
        step();
        checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL ill_after got=%0b exp=0", bus.illegal); end
    endtask
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_multu_interlock();
        test_reset_mid_divu();
        test_illegal();
        chk("final_busy", int'(bus.busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Issue controller for the shared ALU/shifter/multiplier/HiLo datapath.
- Accepts one decoded R-type funct per request and drives the single 6-bit control code shared by the ALU, shifter, multiplier and result mux.
- Sequences the multi-cycle MULTU/DIVU iteration and emits the one-cycle HiLo write code at completion.
- Interlocks every new request, including MFHI/MFLO, while an iteration is in flight.

Parameters:
- ITER_CYCLES, 32, number of iteration cycles for MULTU/DIVU.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > ITER_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- op_valid  input  1  request present this cycle.
- funct  input  6  R-type function code of the request.
- stall  output  1  combinational; request not accepted this cycle, requester holds op_valid/funct.
- ctrl_code  output  6  registered control code to ALU/SHT/MUL/MUX.
- busy  output  1  registered; high in RUN and WRITE.
- hilo_wr  output  1  registered; one-cycle pulse, HiLo capture.
- op_done  output  1  registered; one-cycle pulse when any accepted op completes.
- illegal  output  1  registered; one-cycle pulse for an accepted unsupported funct.

Behaviour:
- Supported funct codes:
  - Single-cycle: AND=36, OR=37, ADD=32, SUB=34, SLT=42, SRL=2, MFHI=16, MFLO=18.
  - Multi-cycle: MULTU=25, DIVU=27.
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0, ctrl_code=0, busy=0, hilo_wr=0, op_done=0, illegal=0, latched op=0.
  - Reset applied mid-RUN aborts the iteration; no hilo_wr is ever issued for it.
- FSM states: IDLE, RUN, WRITE.
- stall = op_valid & (state != IDLE). Stall is never asserted in IDLE.
- IDLE with op_valid:
  - Single-cycle op: next ctrl_code=funct, op_done=1; stay IDLE. Back-to-back single-cycle ops are accepted every cycle.
  - MULTU/DIVU: latch funct, cnt<=0, ctrl_code<=funct, busy<=1; go to RUN.
  - Any other funct: ctrl_code<=0, illegal=1, op_done=0; stay IDLE.
- IDLE without op_valid: ctrl_code<=0.
- RUN:
  - ctrl_code holds the latched funct; cnt increments every cycle.
  - When cnt==ITER_CYCLES-1: go to WRITE, ctrl_code<=6'b111111, hilo_wr<=1, op_done<=1.
  - Exactly ITER_CYCLES cycles are spent in RUN.
- WRITE (one cycle):
  - ctrl_code=6'b111111, hilo_wr=1, op_done=1, busy=1.
  - Next state is IDLE with ctrl_code<=0 and busy<=0, regardless of op_valid. A request held during WRITE is accepted in the following IDLE cycle.
- Latency:
  - Single-cycle op: ctrl_code valid the cycle after acceptance.
  - MULTU/DIVU accepted at edge E0: hilo_wr is high during the cycle after edge E0+ITER_CYCLES. Earliest next acceptance is at edge E0+ITER_CYCLES+2.
- Interlock: funct changes while stall=1 are ignored; the latched op is never altered mid-iteration.
- cnt never wraps; it is only reloaded in IDLE.
- hilo_wr and op_done are never high for more than one consecutive cycle per op.

Test Plan:
- Reset then ADD(32) with op_valid for 1 cycle -> next cycle ctrl_code=32, op_done=1; following cycle ctrl_code=0.
- AND, OR, SLT on 3 consecutive cycles -> ctrl_code=36, 37, 42 on the following 3 cycles; stall=0 throughout.
- MULTU(25) accepted at cycle 0 -> busy=1 and ctrl_code=25 for cycles 1-32; cycle 33 ctrl_code=63, hilo_wr=1, op_done=1; cycle 34 busy=0, ctrl_code=0.
- MFHI(16) presented from cycle 5 during a MULTU -> stall=1 cycles 5-33; accepted at the cycle 34 edge; ctrl_code=16 in cycle 35.
- DIVU(27) started, rst=1 at cycle 10 -> cycle 11 all outputs 0, state IDLE, no hilo_wr pulse afterwards; a new ADD is accepted immediately.
- funct=63 with op_valid in IDLE -> illegal=1 for one cycle, ctrl_code=0, op_done=0, busy=0.
